// File: rtl/alu_sequencer_if.sv
//==============================================================================
// Module      : alu_sequencer_if
// Description : Request and result handshake bundle for alu_sequencer.
//               master = requester/consumer side, slave = sequencer side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alu_sequencer_if;
  // request port
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_lhs;
  logic [7:0] req_rhs;
  logic [1:0] req_shift_op;
  logic [1:0] req_shift_interp;
  logic [3:0] req_logic_op;
  logic [1:0] req_carry_mode;
  // result port
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       res_neg;

  modport master (
    output req_valid, req_lhs, req_rhs, req_shift_op, req_shift_interp,
           req_logic_op, req_carry_mode, res_ready,
    input  req_ready, res_valid, res_data, res_carry, res_zero, res_neg
  );

  modport slave (
    input  req_valid, req_lhs, req_rhs, req_shift_op, req_shift_interp,
           req_logic_op, req_carry_mode, res_ready,
    output req_ready, res_valid, res_data, res_carry, res_zero, res_neg
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
//==============================================================================
// Module      : alu_sequencer
// Description : Issue and result stage around the two-stage alu. Registers the
//               alu operands/controls, delays the carry select one cycle to meet
//               alu stage 2, captures results with zero/negative flags into a
//               first-word-fall-through FIFO and owns the arithmetic carry flag.
//               Optional feature macro: ALU_SEQ_FLUSH_EN (adds i_flush input).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0,
  parameter int RES_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_SEQ_FLUSH_EN
  input  logic             i_flush,
`endif
  alu_sequencer_if.slave   bus,
  output logic [7:0]       o_alu_lhs,
  output logic [7:0]       o_alu_rhs,
  output logic [1:0]       o_alu_shift_op,
  output logic [1:0]       o_alu_shift_interp,
  output logic [3:0]       o_alu_logic_op,
  output logic [1:0]       o_alu_carry_sel,
  input  logic [7:0]       i_alu_result,
  input  logic             i_alu_carry_out,
  output logic             o_carry_flag
);

  localparam int                 c_ptr_w    = $clog2(RES_DEPTH);
  localparam int                 c_cnt_w    = $clog2(RES_DEPTH + 1);
  localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(RES_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(RES_DEPTH - 1);

  // Delay parameters exist for interface compatibility only; reject nonsense values.
  generate
    if (RES_DEPTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
      $error("alu_sequencer: RES_DEPTH must be >= 2 and delays non-negative");
    end
  endgenerate

  // issue registers
  logic [7:0] r_lhs;
  logic [7:0] r_rhs;
  logic [1:0] r_shift_op;
  logic [1:0] r_shift_interp;
  logic [3:0] r_logic_op;
  logic [1:0] r_mode;
  logic [1:0] r_carry_sel;
  // op tokens: V1 = op in alu stage 1 input, V2 = op in alu stage 2
  logic       r_v1;
  logic       r_v2;
  logic       r_carry_flag;
  // result FIFO, entry = {data[7:0], carry, zero, neg}
  logic [10:0]        r_mem [RES_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic             w_flush;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_cin;
  logic             w_flag_next;
  logic [c_cnt_w:0] w_used;
  logic [10:0]      w_head;

`ifdef ALU_SEQ_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Credit counts every op that will eventually land, so the FIFO cannot overflow.
  assign w_used         = {{c_cnt_w{1'b0}}, r_v1} + {{c_cnt_w{1'b0}}, r_v2} + {1'b0, r_count};
  assign bus.req_ready  = (w_used < c_depth) & ~w_flush;
  assign w_accept       = bus.req_valid & bus.req_ready;
  assign w_push         = r_v2 & ~w_flush;
  assign w_pop          = bus.res_valid & bus.res_ready & ~w_flush;

  // Carry flag as it will stand after this edge; forwards the capturing op's carry
  // so a mode-10 op right behind its predecessor sees the fresh value.
  always_comb begin
    w_flag_next = r_carry_flag;
    if (w_flush) begin
      w_flag_next = 1'b0;
    end else if (r_v2) begin
      w_flag_next = i_alu_carry_out;
    end
  end

  // Carry-in selection from the issued op's carry mode; reserved mode acts as 00.
  always_comb begin
    w_cin = 1'b0;
    case (r_mode)
      2'b01:   w_cin = 1'b1;
      2'b10:   w_cin = w_flag_next;
      default: w_cin = 1'b0;
    endcase
  end

  // Issue registers, op tokens, delayed carry select and carry flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lhs          <= 8'h00;
      r_rhs          <= 8'h00;
      r_shift_op     <= 2'b00;
      r_shift_interp <= 2'b00;
      r_logic_op     <= 4'h0;
      r_mode         <= 2'b00;
      r_carry_sel    <= 2'b00;
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      r_carry_flag   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lhs          <= bus.req_lhs;
        r_rhs          <= bus.req_rhs;
        r_shift_op     <= bus.req_shift_op;
        r_shift_interp <= bus.req_shift_interp;
        r_logic_op     <= bus.req_logic_op;
        r_mode         <= bus.req_carry_mode;
      end
      r_v1         <= w_accept;
      r_v2         <= r_v1 & ~w_flush;
      r_carry_sel  <= {1'b0, w_cin};
      r_carry_flag <= w_flag_next;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_alu_result, i_alu_carry_out, (i_alu_result == 8'h00), i_alu_result[7]};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

  assign w_head        = (r_count != '0) ? r_mem[r_rd_ptr] : 11'h000;
  assign bus.res_valid = (r_count != '0);
  assign bus.res_data  = w_head[10:3];
  assign bus.res_carry = w_head[2];
  assign bus.res_zero  = w_head[1];
  assign bus.res_neg   = w_head[0];

  assign o_alu_lhs          = r_lhs;
  assign o_alu_rhs          = r_rhs;
  assign o_alu_shift_op     = r_shift_op;
  assign o_alu_shift_interp = r_shift_interp;
  assign o_alu_logic_op     = r_logic_op;
  assign o_alu_carry_sel    = r_carry_sel;
  assign o_carry_flag       = r_carry_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//==============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a behavioural
//               two-stage alu (shift passes LHS, logic passes RHS, stage 2 adds).
//               Exercises ALU_SEQ_FLUSH_EN flush when that macro is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_lhs;
  logic [7:0] alu_rhs;
  logic [1:0] alu_shift_op;
  logic [1:0] alu_shift_interp;
  logic [3:0] alu_logic_op;
  logic [1:0] alu_carry_sel;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic       carry_flag;
`ifdef ALU_SEQ_FLUSH_EN
  logic       flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(.DELAY_RISE(0), .DELAY_FALL(0), .RES_DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
`ifdef ALU_SEQ_FLUSH_EN
    .i_flush            (flush),
`endif
    .bus                (bus.slave),
    .o_alu_lhs          (alu_lhs),
    .o_alu_rhs          (alu_rhs),
    .o_alu_shift_op     (alu_shift_op),
    .o_alu_shift_interp (alu_shift_interp),
    .o_alu_logic_op     (alu_logic_op),
    .o_alu_carry_sel    (alu_carry_sel),
    .i_alu_result       (alu_result),
    .i_alu_carry_out    (alu_cout),
    .o_carry_flag       (carry_flag)
  );

  always #5 clk = ~clk;

  // Behavioural alu: stage 1 latches pass-LHS / pass-RHS, stage 2 adds with carry select.
  logic [7:0] s1_a;
  logic [7:0] s1_b;
  always_ff @(posedge clk) begin
    s1_a <= alu_lhs;
    s1_b <= alu_rhs;
  end
  assign {alu_cout, alu_result} = {1'b0, s1_a} + {1'b0, s1_b} + {8'h00, alu_carry_sel[0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The carry select must only ever be 00 or 01.
  always @(negedge clk) begin
    if (rst === 1'b0) check_eq("carry_sel_msb", 32'(alu_carry_sel[1]), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] l, input logic [7:0] r, input logic [1:0] m);
    bus.req_valid      = v;
    bus.req_lhs        = l;
    bus.req_rhs        = r;
    bus.req_carry_mode = m;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic c, input logic z, input logic n);
    check_eq({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check_eq({tag, "_data"},  32'(bus.res_data),  32'(d));
    check_eq({tag, "_carry"}, 32'(bus.res_carry), 32'(c));
    check_eq({tag, "_zero"},  32'(bus.res_zero),  32'(z));
    check_eq({tag, "_neg"},   32'(bus.res_neg),   32'(n));
  endtask

  task automatic pop();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  // One op into an empty pipe: result appears exactly two edges after acceptance.
  task automatic run_single(input string tag, input logic [7:0] l, input logic [7:0] r, input logic [1:0] m,
                            input logic [7:0] d, input logic c, input logic z, input logic n);
    drive(1'b1, l, r, m);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    check_eq({tag, "_issue_lhs"}, 32'(alu_lhs), 32'(l));
    check_eq({tag, "_lat1"}, 32'(bus.res_valid), 32'd0);
    tick();
    check_eq({tag, "_lat2"}, 32'(bus.res_valid), 32'd0);
    tick();
    check_head(tag, d, c, z, n);
    check_eq({tag, "_flag"}, 32'(carry_flag), 32'(c));
    pop();
    check_eq({tag, "_empty"}, 32'(bus.res_valid), 32'd0);
    check_eq({tag, "_flag_hold"}, 32'(carry_flag), 32'(c));
  endtask

  logic [7:0] data;
  int         n_acc;

  initial begin
    rst                  = 1'b1;
    bus.req_valid        = 1'b0;
    bus.req_lhs          = 8'h00;
    bus.req_rhs          = 8'h00;
    bus.req_shift_op     = 2'b00;
    bus.req_shift_interp = 2'b00;
    bus.req_logic_op     = 4'hA;
    bus.req_carry_mode   = 2'b00;
    bus.res_ready        = 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
    flush                = 1'b0;
`endif

    // reset state
    tick();
    tick();
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_flag",      32'(carry_flag),    32'd0);
    check_eq("rst_carry_sel", 32'(alu_carry_sel), 32'd0);
    check_eq("rst_alu_lhs",   32'(alu_lhs),       32'd0);
    #2 rst = 1'b0;
    tick();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // single op, latency and flags
    run_single("add3c05", 8'h3C, 8'h05, 2'b00, 8'h41, 1'b0, 1'b0, 1'b0);
    check_eq("logic_op_pass", 32'(alu_logic_op), 32'hA);

    // 16-bit chain 12FF + 0001, high byte back-to-back using carry flag
    drive(1'b1, 8'hFF, 8'h01, 2'b00);
    tick();
    drive(1'b1, 8'h12, 8'h00, 2'b10);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    check_head("chain_lo", 8'h00, 1'b1, 1'b1, 1'b0);
    check_eq("chain_lo_flag", 32'(carry_flag), 32'd1);
    tick();
    check_head("chain_lo_hold", 8'h00, 1'b1, 1'b1, 1'b0);
    pop();
    check_head("chain_hi", 8'h13, 1'b0, 1'b0, 1'b0);
    check_eq("chain_hi_flag", 32'(carry_flag), 32'd0);
    pop();
    check_eq("chain_empty", 32'(bus.res_valid), 32'd0);

    // carry modes: reserved mode ignores a set flag, forced cin, negative result
    run_single("set_flag", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
    run_single("mode11",   8'h10, 8'h20, 2'b11, 8'h30, 1'b0, 1'b0, 1'b0);
    run_single("mode01",   8'h10, 8'h20, 2'b01, 8'h31, 1'b0, 1'b0, 1'b0);
    run_single("neg",      8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1);

    // credit limit with the consumer stalled
    n_acc = 0;
    data  = 8'h01;
    drive(1'b1, data, 8'h00, 2'b00);
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready) begin
        n_acc++;
        tick();
        data++;
        bus.req_lhs = data;
      end else begin
        tick();
      end
    end
    check_eq("credit_accepts", n_acc, 32'd4);
    check_eq("credit_ready0",  32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    check_head("fifo_0", 8'h01, 1'b0, 1'b0, 1'b0);
    pop();
    check_eq("credit_ready1", 32'(bus.req_ready), 32'd1);
    check_head("fifo_1", 8'h02, 1'b0, 1'b0, 1'b0);
    pop();
    check_head("fifo_2", 8'h03, 1'b0, 1'b0, 1'b0);
    pop();
    check_head("fifo_3", 8'h04, 1'b0, 1'b0, 1'b0);
    pop();
    check_eq("fifo_empty", 32'(bus.res_valid), 32'd0);

`ifdef ALU_SEQ_FLUSH_EN
    // flush with one queued and two in flight, request still presented
    drive(1'b1, 8'hFF, 8'h01, 2'b00);
    tick();
    tick();
    tick();
    check_eq("fl_pre_flag",  32'(carry_flag),    32'd1);
    check_eq("fl_pre_ready", 32'(bus.req_ready), 32'd1);
    flush = 1'b1;
    #1;
    check_eq("fl_ready0", 32'(bus.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    check_eq("fl_valid", 32'(bus.res_valid), 32'd0);
    check_eq("fl_flag",  32'(carry_flag),    32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fl_no_late", 32'(bus.res_valid), 32'd0);
    end
    check_eq("fl_flag_hold", 32'(carry_flag), 32'd0);
`endif

    // asynchronous reset with one queued result and two ops in flight
    drive(1'b1, 8'hFF, 8'h01, 2'b00);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    tick();
    check_eq("mid_pre_flag",  32'(carry_flag),    32'd1);
    check_eq("mid_pre_valid", 32'(bus.res_valid), 32'd1);
    drive(1'b1, 8'hFF, 8'h01, 2'b00);
    tick();
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    check_eq("mid_rst_flag",  32'(carry_flag),    32'd0);
    #1 rst = 1'b0;
    check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid_no_late", 32'(bus.res_valid), 32'd0);
      check_eq("mid_flag0",   32'(carry_flag),    32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
